// File: rtl/fpu_op_sequencer.sv
// Purpose: sequences one FPU operation per command: issue, wait (with timeout), acknowledge, present result.
// Latency: legal op ready after N WAIT cycles -> res_valid N+4 cycles after accept; illegal op -> 1 cycle.
// Backpressure: cmd_ready only in IDLE; result and status held stable in DONE until res_ready.
//
// Ports:
//   clk, rst (async active-low)
//   cmd_valid/cmd_ready, cmd_op, cmd_region, cmd_rmode, cmd_data1, cmd_data2 : command in
//   begin_operation, ack_operation, operation, region_flag, r_mode, Data_1, Data_2 : FPU drive
//   operation_ready, op_result, overflow_flag, underflow_flag, NaN_flag           : FPU return
//   res_valid/res_ready, res_data, res_ovf, res_unf, res_nan, res_tmo, res_ill     : result out
//   busy : high whenever the sequencer is not idle
module fpu_op_sequencer #(
    parameter int W   = 64,
    parameter int TMO = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [1:0]   cmd_region,
    input  logic [1:0]   cmd_rmode,
    input  logic [W-1:0] cmd_data1,
    input  logic [W-1:0] cmd_data2,
    output logic         begin_operation,
    output logic         ack_operation,
    output logic [2:0]   operation,
    output logic [1:0]   region_flag,
    output logic [1:0]   r_mode,
    output logic [W-1:0] Data_1,
    output logic [W-1:0] Data_2,
    input  logic         operation_ready,
    input  logic [W-1:0] op_result,
    input  logic         overflow_flag,
    input  logic         underflow_flag,
    input  logic         NaN_flag,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_ovf,
    output logic         res_unf,
    output logic         res_nan,
    output logic         res_tmo,
    output logic         res_ill,
    output logic         busy
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, DONE} state_t;

    // Timer counts completed WAIT cycles; abort on the TMO-th WAIT cycle without ready.
    localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] timer;
    logic        illegal;
    logic        timeout;

    // Unit select 11 has no FPU behind it.
    assign illegal = (cmd_op[2:1] == 2'b11);
    assign timeout = (timer == TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus all handshake outputs, decoded purely from state.
    always_comb begin
        state_nxt       = state;
        cmd_ready       = 1'b0;
        begin_operation = 1'b0;
        ack_operation   = 1'b0;
        res_valid       = 1'b0;
        busy            = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_nxt = illegal ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                begin_operation = 1'b1;
                state_nxt       = WAIT;
            end
            WAIT: begin
                if (operation_ready || timeout) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                ack_operation = 1'b1;
                if (!operation_ready) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand hold registers, result capture and the WAIT timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            operation   <= '0;
            region_flag <= '0;
            r_mode      <= '0;
            Data_1      <= '0;
            Data_2      <= '0;
            res_data    <= '0;
            res_ovf     <= 1'b0;
            res_unf     <= 1'b0;
            res_nan     <= 1'b0;
            res_tmo     <= 1'b0;
            res_ill     <= 1'b0;
            timer       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        operation   <= cmd_op;
                        region_flag <= cmd_region;
                        r_mode      <= cmd_rmode;
                        Data_1      <= cmd_data1;
                        Data_2      <= cmd_data2;
                        res_tmo     <= 1'b0;
                        res_ill     <= illegal;
                        if (illegal) begin
                            res_data <= '0;
                            res_ovf  <= 1'b0;
                            res_unf  <= 1'b0;
                            res_nan  <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    timer <= '0;
                end
                WAIT: begin
                    timer <= timer + 16'd1;
                    if (operation_ready) begin
                        res_data <= op_result;
                        res_ovf  <= overflow_flag;
                        res_unf  <= underflow_flag;
                        res_nan  <= NaN_flag;
                    end else if (timeout) begin
                        res_data <= '0;
                        res_ovf  <= 1'b0;
                        res_unf  <= 1'b0;
                        res_nan  <= 1'b0;
                        res_tmo  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
